gol_generation_scheduler: RTL and testbench
===========================================

// Module: gol_generation_scheduler
// PURPOSE
//   Sequences one Game of Life generation at a time through a row-serial next-state
//   engine and owns the displayed board. Per generation it requests rows 0..ROWS-1
//   from the engine over a req/ack handshake, collects them in a shadow buffer, and
//   commits the buffer to board_o in a single cycle. Handles run/stop, single-step,
//   clear, board load from set-up, generation counting and still-life auto-stop.
// PARAMETERS
//   ROWS   16  board rows; row_idx width = $clog2(ROWS)
//   COLS   16  cells per row; row r = board_o[r*COLS +: COLS]
//   CNT_W  16  generation counter width
// PORTS
//   clk               in   1          system clock
//   reset             in   1          asynchronous, active-high reset
//   cmd_run           in   1          1-cycle pulse: toggles run/stop
//   cmd_step          in   1          1-cycle pulse: compute exactly one generation
//   cmd_clear         in   1          1-cycle pulse: zero board and counter
//   gen_tick          in   1          1-cycle rate pulse: start a generation while running
//   load_en           in   1          1-cycle pulse: accept load_board
//   load_board        in   ROWS*COLS  board from set-up logic
//   row_req           out  1          request to engine for row row_idx
//   row_idx           out  log2 ROWS  row being requested
//   row_ack           in   1          engine: row_data valid for row_idx this cycle
//   row_data          in   COLS       next-state row from the engine
//   board_o           out  ROWS*COLS  current board (engine reads this)
//   generation_cnt_o  out  CNT_W      generations committed since clear/load/reset
//   running_o         out  1          free-run mode active
//   busy_o            out  1          generation in progress
//   stable_o          out  1          last committed generation equals its predecessor
// BEHAVIOUR
//   Reset: every output = 0, state IDLE, stop_pending = 0. Reset during a generation
//     aborts it immediately; row_req drops asynchronously; shadow contents discarded.
//   States: IDLE, RUN_WAIT, FETCH, COMMIT. busy_o = 1 in FETCH and COMMIT.
//   IDLE: priority clear > load > run > step, evaluated per cycle.
//     cmd_clear: board_o = 0, cnt = 0, stable_o = 0.
//     load_en: board_o = load_board, cnt = 0, stable_o = 0.
//     cmd_run: running_o = 1 -> RUN_WAIT.
//     cmd_step: -> FETCH with running_o = 0.
//   RUN_WAIT: cmd_run -> running_o = 0, go to IDLE. gen_tick -> FETCH.
//     load_en, cmd_clear and cmd_step are ignored while running.
//   FETCH: row_idx starts at 0; row_req = 1 for the whole state.
//     On clk with row_ack = 1: shadow[row_idx] = row_data.
//       If row_idx < ROWS-1: row_idx++ on the same edge and row_req stays high.
//       Else: -> COMMIT.
//     The engine must present data for the row_idx visible in its ack cycle.
//   COMMIT (1 cycle, row_req = 0):
//     board_o = shadow. cnt++ with wrap (all-ones -> 0).
//     stable_o = (shadow == old board_o).
//     If stable_o, running_o = 0 (auto-stop).
//     If stop_pending, running_o = 0 and stop_pending is cleared.
//     Next state: RUN_WAIT if running_o else IDLE. row_idx returns to 0.
//   During FETCH/COMMIT:
//     cmd_run while running sets stop_pending; the current generation always completes.
//     gen_tick, cmd_step, cmd_clear and load_en are dropped, not queued.
//   Latency: step pulse -> row_req high next cycle.
//     Last ack -> board_o updates 2 edges later (COMMIT edge).
//     Best case is ROWS+1 cycles per generation.
//   row_ack is ignored when row_req = 0.
// TESTING
//   Reset: assert reset mid-stream -> all outputs 0 at once; row_req 0 without a clock edge.
//   Step: load horizontal blinker (row7 = 16'h01C0), cmd_step; engine model acks 2 cycles
//     after each req -> row_idx sequence 0..15, board_o rows 6/7/8 = 16'h0080,
//     cnt = 1, running_o = 0.
//   Run/stop: cmd_run, gen_tick every 100 cycles -> board alternates blinker phases,
//     cnt = 1, 2, 3; cmd_run during FETCH row 9 -> generation finishes, cnt = 4,
//     running_o = 0, no further req.
//   Still life: load 2x2 block, cmd_run, tick -> cnt = 1, stable_o = 1,
//     running_o auto-clears, later gen_tick ignored.
//   Wrap and drops (CNT_W = 4): 16 steps -> cnt = 0. gen_tick, load_en and cmd_clear
//     during FETCH -> no effect on board_o or cnt.
//   Priority: cmd_clear and load_en in the same IDLE cycle -> board_o = 0, cnt = 0.

Source files
------------

// File: rtl/gol_generation_scheduler.sv
// Game of Life generation sequencer: fetches next-state rows from a
// row-serial engine into a shadow buffer and commits them in one cycle.
module gol_generation_scheduler #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int CNT_W = 16,
  localparam int IW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_run,
  input  logic                 cmd_step,
  input  logic                 cmd_clear,
  input  logic                 gen_tick,
  input  logic                 load_en,
  input  logic [ROWS*COLS-1:0] load_board,
  output logic                 row_req,
  output logic [IW-1:0]        row_idx,
  input  logic                 row_ack,
  input  logic [COLS-1:0]      row_data,
  output logic [ROWS*COLS-1:0] board_o,
  output logic [CNT_W-1:0]     generation_cnt_o,
  output logic                 running_o,
  output logic                 busy_o,
  output logic                 stable_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN_WAIT,
    FETCH,
    COMMIT
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 stop_pending_q;
  logic [ROWS*COLS-1:0] shadow_q;
  logic                 last_row;
  logic                 stop_now;
  logic                 same;

  assign row_req  = (state_q == FETCH);
  assign busy_o   = (state_q == FETCH) || (state_q == COMMIT);
  assign last_row = (row_idx == IW'(ROWS - 1));
  assign same     = (shadow_q == board_o);
  // a run toggle landing on the commit cycle stops like a pending one
  assign stop_now = stop_pending_q | (cmd_run & running_o);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_clear || load_en) begin
          state_d = IDLE;
        end else if (cmd_run) begin
          state_d = RUN_WAIT;
        end else if (cmd_step) begin
          state_d = FETCH;
        end
      end
      RUN_WAIT: begin
        if (cmd_run) begin
          state_d = IDLE;
        end else if (gen_tick) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (row_ack && last_row) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        if (running_o && !same && !stop_now) begin
          state_d = RUN_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      board_o          <= '0;
      generation_cnt_o <= '0;
      running_o        <= 1'b0;
      stable_o         <= 1'b0;
      stop_pending_q   <= 1'b0;
      row_idx          <= '0;
      shadow_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_clear) begin
            board_o          <= '0;
            generation_cnt_o <= '0;
            stable_o         <= 1'b0;
          end else if (load_en) begin
            board_o          <= load_board;
            generation_cnt_o <= '0;
            stable_o         <= 1'b0;
          end else if (cmd_run) begin
            running_o <= 1'b1;
          end else if (cmd_step) begin
            running_o <= 1'b0;
          end
        end
        RUN_WAIT: begin
          if (cmd_run) begin
            running_o <= 1'b0;
          end
        end
        FETCH: begin
          if (cmd_run && running_o) begin
            stop_pending_q <= 1'b1;
          end
          if (row_ack) begin
            shadow_q[row_idx*COLS +: COLS] <= row_data;
            if (!last_row) begin
              row_idx <= row_idx + IW'(1);
            end
          end
        end
        COMMIT: begin
          board_o          <= shadow_q;
          generation_cnt_o <= generation_cnt_o + CNT_W'(1);
          stable_o         <= same;
          stop_pending_q   <= 1'b0;
          row_idx          <= '0;
          if (same || stop_now) begin
            running_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gol_generation_scheduler.sv
// Directed bench for gol_generation_scheduler with a Game of Life
// engine model that acks each row request two cycles after it rises.
module tb_gol_generation_scheduler;

  localparam int R = 16;
  localparam int C = 16;
  localparam int CW = 4;

  logic           clk = 0;
  logic           reset = 1;
  logic           cmd_run = 0, cmd_step = 0, cmd_clear = 0;
  logic           gen_tick = 0, load_en = 0;
  logic [R*C-1:0] load_board = '0;
  logic           row_req;
  logic [3:0]     row_idx;
  logic           row_ack = 0;
  logic [C-1:0]   row_data = '0;
  logic [R*C-1:0] board_o;
  logic [CW-1:0]  generation_cnt_o;
  logic           running_o, busy_o, stable_o;

  int n_vec = 0;
  int n_bad = 0;
  int dly = 0;
  logic eng_en = 1;
  int idx_log[$];

  gol_generation_scheduler #(.ROWS(R), .COLS(C), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_clear(cmd_clear),
    .gen_tick(gen_tick), .load_en(load_en), .load_board(load_board),
    .row_req(row_req), .row_idx(row_idx), .row_ack(row_ack),
    .row_data(row_data), .board_o(board_o),
    .generation_cnt_o(generation_cnt_o), .running_o(running_o),
    .busy_o(busy_o), .stable_o(stable_o)
  );

  always #5 clk = ~clk;

  function automatic logic [C-1:0] life_row(logic [R*C-1:0] b, int r);
    logic [C-1:0] o;
    int nb, rr, cc;
    o = '0;
    for (int c = 0; c < C; c++) begin
      nb = 0;
      for (int dr = -1; dr <= 1; dr++)
        for (int dc = -1; dc <= 1; dc++) begin
          rr = r + dr;
          cc = c + dc;
          if (!(dr == 0 && dc == 0) && rr >= 0 && rr < R && cc >= 0 && cc < C)
            nb += int'(b[rr*C+cc]);
        end
      o[c] = (nb == 3) || (nb == 2 && b[r*C+c]);
    end
    return o;
  endfunction

  always @(negedge clk) begin
    if (row_req && eng_en) begin
      if (dly == 1) begin
        row_ack = 1;
        row_data = life_row(board_o, int'(row_idx));
        idx_log.push_back(int'(row_idx));
        dly = 0;
      end else begin
        row_ack = 0;
        dly++;
      end
    end else begin
      row_ack = 0;
      dly = 0;
    end
  end

  task automatic chk(string nm, logic [R*C-1:0] act, logic [R*C-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic pulse(logic clr, logic ld, logic run, logic stp,
                       logic tick, logic [R*C-1:0] lb);
    @(negedge clk);
    cmd_clear = clr; load_en = ld; cmd_run = run;
    cmd_step = stp; gen_tick = tick; load_board = lb;
    @(posedge clk);
    #1;
    cmd_clear = 0; load_en = 0; cmd_run = 0;
    cmd_step = 0; gen_tick = 0;
  endtask

  task automatic wait_idle(string nm);
    int k = 0;
    while (busy_o && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_vec++;
    if (busy_o) begin
      n_bad++;
      $display("FAIL %s: timeout busy=%b want 0", nm, busy_o);
    end
  endtask

  task automatic wait_row(int r, string nm);
    int k = 0;
    while (!(row_req && int'(row_idx) == r) && k < 300) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (!(row_req && int'(row_idx) == r)) begin
      n_bad++;
      $display("FAIL %s: timeout row_idx=%0d want %0d", nm, row_idx, r);
    end
  endtask

  typedef struct {
    logic           clr, ld, run, stp;
    logic [R*C-1:0] lb;
    logic [R*C-1:0] eb;
    int             ec;
    logic           er;
  } vec_t;

  vec_t tbl[9];
  logic [R*C-1:0] bh, bv, blk;
  logic [63:0] seq_act, seq_exp;

  initial begin
    bh = '0;  bh[7*C +: C] = 16'h01C0;
    bv = '0;
    bv[6*C +: C] = 16'h0080;
    bv[7*C +: C] = 16'h0080;
    bv[8*C +: C] = 16'h0080;
    blk = '0; blk[4*C +: C] = 16'h0030; blk[5*C +: C] = 16'h0030;

    tbl[0] = '{0, 1, 0, 0, bh,  bh,  0, 0};
    tbl[1] = '{0, 0, 1, 0, '0,  bh,  0, 1};
    tbl[2] = '{0, 1, 0, 0, blk, bh,  0, 1};
    tbl[3] = '{1, 0, 0, 0, '0,  bh,  0, 1};
    tbl[4] = '{0, 0, 1, 0, '0,  bh,  0, 0};
    tbl[5] = '{0, 1, 0, 1, blk, blk, 0, 0};
    tbl[6] = '{1, 1, 1, 1, bh,  '0,  0, 0};
    tbl[7] = '{0, 1, 0, 0, blk, blk, 0, 0};
    tbl[8] = '{1, 1, 0, 0, bh,  '0,  0, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_board", board_o, '0);
    chk("reset_flags", 256'({row_req, running_o, busy_o, stable_o, generation_cnt_o}), '0);
    @(negedge clk);
    reset = 0;

    for (int i = 0; i < 9; i++) begin
      pulse(tbl[i].clr, tbl[i].ld, tbl[i].run, tbl[i].stp, 1'b0, tbl[i].lb);
      chk($sformatf("vec%0d_board", i), board_o, tbl[i].eb);
      chk($sformatf("vec%0d_state", i),
          256'({generation_cnt_o, running_o, busy_o, stable_o}),
          256'({CW'(tbl[i].ec), tbl[i].er, 1'b0, 1'b0}));
    end

    // single step of a blinker
    pulse(0, 1, 0, 0, 0, bh);
    idx_log.delete();
    pulse(0, 0, 0, 1, 0, '0);
    chk("step_req_next", 256'({row_req, busy_o}), 256'(2'b11));
    wait_idle("step_done");
    chk("step_board", board_o, bv);
    chk("step_state", 256'({generation_cnt_o, running_o, stable_o}),
        256'({CW'(1), 1'b0, 1'b0}));
    seq_act = '0;
    seq_exp = '0;
    for (int i = 0; i < R; i++) begin
      seq_exp[i*4 +: 4] = 4'(i);
      if (i < idx_log.size()) seq_act[i*4 +: 4] = 4'(idx_log[i]);
    end
    chk("row_idx_seq", 256'({idx_log.size() == R, seq_act}), 256'({1'b1, seq_exp}));

    // free run with a stop request mid-generation
    pulse(0, 1, 0, 0, 0, bh);
    pulse(0, 0, 1, 0, 0, '0);
    for (int g = 1; g <= 3; g++) begin
      pulse(0, 0, 0, 0, 1, '0);
      repeat (99) @(posedge clk);
      #1;
      chk($sformatf("run_g%0d_board", g), board_o, (g % 2 == 1) ? bv : bh);
      chk($sformatf("run_g%0d_state", g), 256'({generation_cnt_o, running_o, busy_o}),
          256'({CW'(g), 1'b1, 1'b0}));
    end
    pulse(0, 0, 0, 0, 1, '0);
    wait_row(9, "run_row9");
    pulse(0, 0, 1, 0, 0, '0);
    chk("stop_pending_busy", 256'(busy_o), 256'(1));
    wait_idle("stop_done");
    chk("stop_board", board_o, bh);
    chk("stop_state", 256'({generation_cnt_o, running_o}), 256'({CW'(4), 1'b0}));
    pulse(0, 0, 0, 0, 1, '0);
    repeat (5) @(posedge clk);
    #1;
    chk("stop_no_req", 256'({row_req, busy_o, generation_cnt_o}), 256'({2'b00, CW'(4)}));

    // still life auto-stop
    pulse(0, 1, 0, 0, 0, blk);
    pulse(0, 0, 1, 0, 0, '0);
    pulse(0, 0, 0, 0, 1, '0);
    wait_idle("still_done");
    chk("still_state", 256'({generation_cnt_o, stable_o, running_o}),
        256'({CW'(1), 1'b1, 1'b0}));
    chk("still_board", board_o, blk);
    pulse(0, 0, 0, 0, 1, '0);
    repeat (5) @(posedge clk);
    #1;
    chk("still_tick_ignored", 256'({busy_o, generation_cnt_o}), 256'({1'b0, CW'(1)}));

    // counter wrap after 16 single steps
    pulse(0, 1, 0, 0, 0, bh);
    for (int s = 0; s < 16; s++) begin
      pulse(0, 0, 0, 1, 0, '0);
      wait_idle($sformatf("wrap_step%0d", s));
    end
    chk("wrap_cnt", 256'(generation_cnt_o), 256'(0));
    chk("wrap_board", board_o, bh);

    // commands arriving mid-fetch are dropped
    eng_en = 0;
    pulse(0, 0, 0, 1, 0, '0);
    pulse(0, 0, 0, 0, 1, '0);
    pulse(0, 1, 0, 0, 0, blk);
    pulse(1, 0, 0, 0, 0, '0);
    pulse(0, 0, 0, 1, 0, '0);
    eng_en = 1;
    wait_idle("drop_done");
    chk("drop_board", board_o, bv);
    chk("drop_cnt", 256'(generation_cnt_o), 256'(1));

    // asynchronous reset in the middle of a fetch
    pulse(0, 0, 0, 1, 0, '0);
    wait_row(5, "rst_row5");
    @(negedge clk);
    reset = 1;
    #1;
    chk("rst_async_req", 256'({row_req, busy_o, running_o}), '0);
    chk("rst_async_board", board_o, '0);
    chk("rst_async_cnt", 256'({generation_cnt_o, row_idx, stable_o}), '0);
    @(negedge clk);
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_after", 256'({row_req, busy_o, generation_cnt_o}), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
